// File: rtl/poly_eval_pkg.sv
// Shared types and default sizes for the Horner polynomial evaluator.
package poly_eval_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_COEF_W  = 16;
  localparam int DEF_X_W     = 16;
  localparam int DEF_ACC_W   = 32;
  localparam int DEF_MAX_DEG = 7;
  localparam int DEF_DEG_W   = 4;

  // Address width for a register file of 'depth' entries, never below one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/poly_mac.sv
// One Horner step: acc*x + c with an overflow flag.
// POLY_SATURATE_EN: once overflow is seen the result is pinned to all-ones.
module poly_mac
  import poly_eval_pkg::*;
#(
  parameter int COEF_W = DEF_COEF_W,
  parameter int X_W    = DEF_X_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [X_W-1:0]    i_x,
  input  logic [COEF_W-1:0] i_coef,
  input  logic              i_ovf,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_ovf
);

  localparam int PROD_W = ACC_W + X_W;

  logic [PROD_W-1:0] w_prod;
  logic [PROD_W:0]   w_sum;
  logic              w_step_ovf;

  // Full-width product and sum so that any bit above ACC_W flags overflow.
  always_comb begin
    w_prod     = {{X_W{1'b0}}, i_acc} * {{ACC_W{1'b0}}, i_x};
    w_sum      = {1'b0, w_prod} + (PROD_W + 1)'(i_coef);
    w_step_ovf = |w_sum[PROD_W:ACC_W];
    o_ovf      = i_ovf | w_step_ovf;
`ifdef POLY_SATURATE_EN
    if (o_ovf) begin
      o_acc = {ACC_W{1'b1}};
    end else begin
      o_acc = w_sum[ACC_W-1:0];
    end
`else
    o_acc = w_sum[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/poly_horner_eval.sv
// Handshaked Horner-rule polynomial evaluator with an internal coefficient file.
// Optional POLY_SATURATE_EN clamps overflowing results to all-ones.
module poly_horner_eval
  import poly_eval_pkg::*;
#(
  parameter int COEF_W  = DEF_COEF_W,
  parameter int X_W     = DEF_X_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MAX_DEG = DEF_MAX_DEG,
  parameter int DEG_W   = DEF_DEG_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            coef_we,
  input  logic [addr_w(MAX_DEG+1)-1:0]    coef_addr,
  input  logic [COEF_W-1:0]               coef_wdata,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [X_W-1:0]                  x_in,
  input  logic [DEG_W-1:0]                n_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ACC_W-1:0]                y_out,
  output logic                            overflow,
  output logic                            busy
);

  localparam int              AW    = addr_w(MAX_DEG + 1);
  localparam logic [DEG_W-1:0] MAX_N = DEG_W'(MAX_DEG);
  localparam logic [AW:0]     TOP_A = (AW + 1)'(MAX_DEG);

  state_t             r_state;
  logic [COEF_W-1:0]  r_coef [0:MAX_DEG];
  logic [X_W-1:0]     r_x;
  logic [DEG_W-1:0]   r_k;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;

  logic [DEG_W-1:0]   w_n;
  logic [DEG_W-1:0]   w_k_dec;
  logic [COEF_W-1:0]  w_start_coef;
  logic [COEF_W-1:0]  w_step_coef;
  logic               w_accept;
  logic               w_coef_wr;
  logic [ACC_W-1:0]   w_mac_acc;
  logic               w_mac_ovf;

  // Request decode: degree clamp and the coefficients read by the start and the current step.
  always_comb begin
    w_n          = (n_in > MAX_N) ? MAX_N : n_in;
    w_k_dec      = r_k - DEG_W'(1);
    w_start_coef = r_coef[AW'(w_n)];
    w_step_coef  = r_coef[AW'(w_k_dec)];
    w_accept     = in_valid && in_ready && (r_state == IDLE);
    w_coef_wr    = coef_we && (r_state == IDLE) && ({1'b0, coef_addr} <= TOP_A);
  end

  poly_mac #(
    .COEF_W (COEF_W),
    .X_W    (X_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .i_acc  (r_acc),
    .i_x    (r_x),
    .i_coef (w_step_coef),
    .i_ovf  (r_ovf),
    .o_acc  (w_mac_acc),
    .o_ovf  (w_mac_ovf)
  );

  // Coefficient file; writes outside IDLE are dropped so evaluation sees stable data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= MAX_DEG; i++) begin
        r_coef[i] <= '0;
      end
    end else if (w_coef_wr) begin
      r_coef[coef_addr] <= coef_wdata;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_x       <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y_out     <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x      <= x_in;
            r_k      <= w_n;
            r_acc    <= ACC_W'(w_start_coef);
            r_ovf    <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (w_n == '0) begin
              r_state   <= DONE;
              out_valid <= 1'b1;
              y_out     <= ACC_W'(w_start_coef);
              overflow  <= 1'b0;
            end else begin
              r_state <= EVAL;
            end
          end
        end
        EVAL: begin
          r_acc <= w_mac_acc;
          r_ovf <= w_mac_ovf;
          r_k   <= w_k_dec;
          if (r_k == DEG_W'(1)) begin
            r_state   <= DONE;
            out_valid <= 1'b1;
            y_out     <= w_mac_acc;
            overflow  <= w_mac_ovf;
          end
        end
        DONE: begin
          // y_out and overflow keep their values after the handshake.
          if (out_ready) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_horner_eval.sv
// Scoreboard bench for poly_horner_eval: stimulus pushes expected results, a monitor pops them.
module tb_poly_horner_eval;

  logic        clk = 1'b0;
  logic        reset;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_in;
  logic [3:0]  n_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y_out;
  logic        overflow;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [31:0] q_y [$];
  logic        q_o [$];

  always #5 clk = ~clk;

  poly_horner_eval dut (
    .clk        (clk),
    .reset      (reset),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x_in       (x_in),
    .n_in       (n_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y_out      (y_out),
    .overflow   (overflow),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference for a polynomial whose coefficients all equal cv.
  function automatic logic [32:0] ref_eval(input logic [15:0] cv, input logic [15:0] x, input int n);
    logic [31:0] acc;
    logic [63:0] full;
    logic        ovf;
    acc = {16'd0, cv};
    ovf = 1'b0;
    for (int k = n; k >= 1; k--) begin
      full = ({32'd0, acc} * {48'd0, x}) + {48'd0, cv};
      if (full[63:32] != 32'd0) ovf = 1'b1;
      acc = full[31:0];
`ifdef POLY_SATURATE_EN
      if (ovf) acc = 32'hFFFF_FFFF;
`endif
    end
    return {ovf, acc};
  endfunction

  // Monitor: compare every accepted result against the head of the scoreboard.
  always @(negedge clk) begin
    logic [31:0] ey;
    logic        eo;
    #2;
    if (reset && out_valid && out_ready) begin
      if (q_y.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got y=0x%0h, expected no output", y_out);
      end else begin
        ey = q_y.pop_front();
        eo = q_o.pop_front();
        check("y_out", {32'd0, y_out}, {32'd0, ey});
        check("overflow", {63'd0, overflow}, {63'd0, eo});
      end
    end
  end

  task automatic expect_res(input logic [31:0] y, input logic o);
    q_y.push_back(y);
    q_o.push_back(o);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 100);
    check({tag, "_idle"}, {63'd0, in_ready}, 64'd1);
  endtask

  // Issue one request; returns at the first negedge where out_valid is seen.
  task automatic do_req(input logic [15:0] x, input logic [3:0] n, input int exp_lat,
                        input string tag, output int waited);
    int cyc;
    @(negedge clk);
    in_valid = 1'b1; x_in = x; n_in = n;
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_accept"}, {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      check({tag, "_in_ready_low"}, {63'd0, in_ready}, 64'd0);
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
  endtask

  initial begin
    int w;
    logic [32:0] r;
    reset = 1'b0; coef_we = 1'b0; coef_addr = 3'd0; coef_wdata = 16'd0;
    in_valid = 1'b0; x_in = 16'd0; n_in = 4'd0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_y_out", {32'd0, y_out}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b1;

    // Basic: 1 + 2*2 + 3*4 = 17
    wr(3'd0, 16'd1); wr(3'd1, 16'd2); wr(3'd2, 16'd3);
    expect_res(32'd17, 1'b0);
    do_req(16'd2, 4'd2, 3, "basic", w);
    wait_idle("basic");

    // Backpressure: 1 + 2*3 + 3*9 = 34 held; writes in DONE are dropped
    out_ready = 1'b0;
    expect_res(32'd34, 1'b0);
    do_req(16'd3, 4'd2, 3, "bp", w);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_hold", {63'd0, out_valid}, 64'd1);
      check("bp_y_hold", {32'd0, y_out}, 64'd34);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_busy", {63'd0, busy}, 64'd1);
      coef_we = 1'b1; coef_addr = 3'(i % 3); coef_wdata = 16'd100;
      @(negedge clk);
    end
    coef_we = 1'b0;
    out_ready = 1'b1;
    wait_idle("bp");
    expect_res(32'd6, 1'b0);
    do_req(16'd1, 4'd2, 3, "old_coef", w);
    wait_idle("old_coef");

    // Degree zero
    wr(3'd0, 16'h1234);
    expect_res(32'h1234, 1'b0);
    do_req(16'd9, 4'd0, 1, "deg0", w);
    wait_idle("deg0");

    // Clamp: n_in=15 evaluates degree 7, all ones -> 8
    for (int k = 0; k < 8; k++) wr(3'(k), 16'd1);
    expect_res(32'd8, 1'b0);
    do_req(16'd1, 4'd15, 8, "clamp", w);
    wait_idle("clamp");

    // Overflow
    for (int k = 0; k < 8; k++) wr(3'(k), 16'hFFFF);
    r = ref_eval(16'hFFFF, 16'hFFFF, 7);
    expect_res(r[31:0], r[32]);
    do_req(16'hFFFF, 4'd7, 8, "ovf", w);
    wait_idle("ovf");

    // Write and request in the same IDLE cycle: request sees old c0
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'd50;
    in_valid = 1'b1; x_in = 16'd0; n_in = 4'd0;
    expect_res(32'h0000_FFFF, 1'b0);
    @(negedge clk);
    coef_we = 1'b0; in_valid = 1'b0;
    wait_idle("same_cycle");
    expect_res(32'd50, 1'b0);
    do_req(16'd0, 4'd0, 1, "post_write", w);
    wait_idle("post_write");

    // Reset during the second EVAL cycle of a degree-7 evaluation
    @(negedge clk);
    in_valid = 1'b1; x_in = 16'd1; n_in = 4'd7;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_y_out", {32'd0, y_out}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    expect_res(32'd0, 1'b0);
    do_req(16'd7, 4'd1, 2, "post_reset", w);
    wait_idle("post_reset");

    // Back-to-back: 1 + 3 = 4, then 1 + 5 = 6
    wr(3'd0, 16'd1); wr(3'd1, 16'd1);
    expect_res(32'd4, 1'b0);
    expect_res(32'd6, 1'b0);
    do_req(16'd3, 4'd1, 2, "b2b_a", w);
    do_req(16'd5, 4'd1, 2, "b2b_b", w);
    check("b2b_accept_wait", 64'(w), 64'd0);
    wait_idle("b2b");

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(q_y.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
